// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: one outstanding imem request, valid/ready hand-off to decode, redirects.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC.
module pc_fetch_sequencer #(
  parameter int              PC_W     = 10,
  parameter int              IMM_W    = 21,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC = PC_W'('h3F0)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_out,
  output logic [PC_W-1:0]  instr_pc,
  input  logic             redir_valid,
  input  logic [1:0]       redir_kind,
  input  logic [PC_W-1:0]  redir_pc,
  input  logic [IMM_W-1:0] redir_imm,
  input  logic [31:0]      redir_rs1,
  output logic [PC_W-1:0]  pc_out,
  output logic             misalign
);

  // state | meaning
  // IDLE  | first cycle after reset release
  // REQ   | imem_req high, imem_addr = pc_out held until gnt
  // WAIT  | granted, waiting for rvalid
  // HOLD  | instr_valid high until decode accepts
  // FLUSH | request outstanding but stale; discard its response
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_FLUSH} state_t;
  state_t state;

  localparam logic [1:0] KIND_JALR = 2'b11;

  logic [31:0]     imm_sext;
  logic [31:0]     target_sum;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] redir_dest;
  logic            redir_hit;
  logic            redir_bad;
  logic            unused_bits;

  assign imm_sext   = {{(32-IMM_W){redir_imm[IMM_W-1]}}, redir_imm};
  assign target_sum = (redir_kind == KIND_JALR) ? ((redir_rs1 + imm_sext) & ~32'd1)
                                                : (32'(redir_pc) + imm_sext);
  assign target     = target_sum[PC_W-1:0];
  assign redir_hit  = redir_valid && (redir_kind != 2'b00);
  assign redir_bad  = (target[1:0] != 2'b00);

`ifdef MISALIGN_TRAP_EN
  assign redir_dest  = redir_bad ? TRAP_VEC : target;
  assign unused_bits = ^{target_sum[31:PC_W]};
`else
  assign redir_dest  = {target[PC_W-1:2], 2'b00};
  assign unused_bits = ^{target_sum[31:PC_W], target[1:0], redir_bad, TRAP_VEC};
`endif

  assign imem_addr = pc_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pc_out      <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (redir_hit && state != ST_IDLE) misalign <= redir_bad;
`endif
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (redir_hit) pc_out <= redir_dest;
          if (imem_gnt) begin
            // a grant alongside a redirect fetches the old PC; its data is discarded
            state    <= redir_hit ? ST_FLUSH : ST_WAIT;
            imem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (redir_hit) begin
              pc_out   <= redir_dest;
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              instr_out   <= imem_rdata;
              instr_pc    <= pc_out;
              instr_valid <= 1'b1;
              pc_out      <= pc_out + PC_W'(4);
              state       <= ST_HOLD;
            end
          end else if (redir_hit) begin
            pc_out <= redir_dest;
            state  <= ST_FLUSH;
          end
        end
        ST_HOLD: begin
          if (redir_hit) pc_out <= redir_dest;
          if (redir_hit || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= ST_REQ;
            imem_req    <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (redir_hit) pc_out <= redir_dest;
          if (imem_rvalid) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; expected PCs are hand-computed.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [9:0]  redir_pc;
  logic [20:0] redir_imm;
  logic [31:0] redir_rs1;
  logic [9:0]  pc_out;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_rs1(redir_rs1),
    .pc_out(pc_out), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for a request, grant it, return word one cycle later, check the hand-off
  task automatic issue(input logic [9:0] addr, input logic [31:0] word);
    logic [9:0] nxt;
    int n;
    n = 0;
    nxt = addr + 10'd4;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(addr));
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("req_drop", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr_out", instr_out, word);
    check("instr_pc", 32'(instr_pc), 32'(addr));
    check("pc_inc", 32'(pc_out), 32'(nxt));
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("valid_clr", 32'(instr_valid), 32'd0);
    check("req_again", 32'(imem_req), 32'd1);
  endtask

  task automatic redirect(input logic [1:0] kind, input logic [9:0] rpc,
                          input logic [20:0] imm, input logic [31:0] rs1);
    redir_valid = 1'b1;
    redir_kind  = kind;
    redir_pc    = rpc;
    redir_imm   = imm;
    redir_rs1   = rs1;
    tick();
    redir_valid = 1'b0;
    redir_kind  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    redir_valid = 1'b0; redir_kind = 2'b00; redir_pc = '0; redir_imm = '0; redir_rs1 = '0;
    tick();
    tick();
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    reset_n = 1'b1;

    // sequential fetch
    issue(10'd0, 32'h1111_0000); accept();
    issue(10'd4, 32'h2222_0004); accept();
    issue(10'd8, 32'h3333_0008); accept();
    check("pc_after3", 32'(pc_out), 32'd12);

    // decode stall in HOLD
    issue(10'd12, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr_out, 32'hCAFE_F00D);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    accept();

    // branch in HOLD with ready asserted in the same cycle
    issue(10'd16, 32'hAAAA_0010);
    instr_ready = 1'b1;
    redirect(2'b01, 10'd8, 21'd196, 32'd0);
    instr_ready = 1'b0;
    check("br_pc", 32'(pc_out), 32'd204);
    check("br_valid", 32'(instr_valid), 32'd0);
    check("br_req", 32'(imem_req), 32'd1);

    // JAL while REQ awaits grant
    redirect(2'b10, 10'd16, 21'd800, 32'd0);
    check("jal_pc", 32'(pc_out), 32'd816);
    check("jal_addr", 32'(imem_addr), 32'd816);
    check("jal_req", 32'(imem_req), 32'd1);

    // redirect in WAIT before rvalid: response discarded
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect(2'b01, 10'd100, 21'd28, 32'd0);
    check("flush_pc", 32'(pc_out), 32'd128);
    check("flush_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("flush_drop", 32'(instr_valid), 32'd0);
    check("flush_addr", 32'(imem_addr), 32'd128);
    issue(10'd128, 32'h5555_0080); accept();

    // kind=00 ignored, negative immediate, JALR
    redirect(2'b00, 10'd500, 21'd4, 32'd0);
    check("kind0_pc", 32'(pc_out), 32'd132);
    redirect(2'b01, 10'd40, 21'h1FFFF8, 32'd0);
    check("neg_imm_pc", 32'(pc_out), 32'd32);
    redirect(2'b11, 10'd0, 21'd20, 32'd15);
`ifdef MISALIGN_TRAP_EN
    check("jalr_pc", 32'(pc_out), 32'h3F0);
    check("jalr_misalign", 32'(misalign), 32'd1);
`else
    check("jalr_pc", 32'(pc_out), 32'd32);
    check("jalr_misalign", 32'(misalign), 32'd0);
`endif
    tick();
    check("misalign_pulse", 32'(misalign), 32'd0);
    redirect(2'b11, 10'd0, 21'd20, 32'd16);
    check("jalr_aligned", 32'(pc_out), 32'd36);
    check("jalr_ok_mis", 32'(misalign), 32'd0);

    // wrap at top of address space
    redirect(2'b10, 10'd1000, 21'd20, 32'd0);
    check("to_1020", 32'(pc_out), 32'd1020);
    issue(10'd1020, 32'h7777_03FC);
    check("wrap_pc", 32'(pc_out), 32'd0);
    accept();

    // async reset in WAIT, then a stale response after release
    redirect(2'b10, 10'd100, 21'd100, 32'd0);
    check("pre_rst_pc", 32'(pc_out), 32'd200);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc_out), 32'd0);
    check("arst_req", 32'(imem_req), 32'd0);
    tick();
    reset_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    check("stale_ignored", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    issue(10'd0, 32'h9999_0000); accept();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
